// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, price check, item handshake, greedy change payout.
// All outputs registered; valid outputs hold with stable data until the matching ready is sampled.
module vend_controller #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_valid,
   input  logic [7:0] coin_value,
   input  logic       sel_valid,
   input  logic [2:0] sel_type,
   input  logic       cancel,
   input  logic       item_ready,
   input  logic       coin_out_ready,
   output logic [7:0] credit,
   output logic       item_valid,
   output logic [2:0] item_type,
   output logic       coin_out_valid,
   output logic [7:0] coin_out_value,
   output logic       coin_reject,
   output logic       sel_nack,
   output logic       done,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, DONE} state_t;

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [7:0]    price;
   logic [TW-1:0] tcnt;

   function automatic logic [7:0] price_of(input logic [2:0] code);
      case (code)
         3'd1:    price_of = 8'd110;
         3'd2:    price_of = 8'd150;
         3'd3:    price_of = 8'd190;
         3'd4:    price_of = 8'd230;
         3'd5:    price_of = 8'd243;
         3'd6:    price_of = 8'd30;
         default: price_of = 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] greedy(input logic [7:0] rem);
      if (rem >= 8'd50)      greedy = 8'd50;
      else if (rem >= 8'd10) greedy = 8'd10;
      else if (rem >= 8'd5)  greedy = 8'd5;
      else                   greedy = 8'd1;
   endfunction

   logic [8:0] sum;
   logic       coin_ok;
   logic [7:0] sel_price;
   logic       sel_ok;
   logic [7:0] vend_rem;
   logic [7:0] chg_rem;
   logic       timeout;

   assign sum       = {1'b0, credit} + {1'b0, coin_value};
   assign coin_ok   = coin_valid && (coin_value != 8'd0) && (sum <= 9'd255);
   assign sel_price = price_of(sel_type);
   assign sel_ok    = (sel_price != 8'd0) && (credit >= sel_price);
   assign vend_rem  = credit - price;
   assign chg_rem   = credit - coin_out_value;
   assign timeout   = !sel_valid && !coin_valid && (tcnt == TLAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         price          <= 8'd0;
         tcnt           <= '0;
         credit         <= 8'd0;
         item_valid     <= 1'b0;
         item_type      <= 3'd0;
         coin_out_valid <= 1'b0;
         coin_out_value <= 8'd0;
         coin_reject    <= 1'b0;
         sel_nack       <= 1'b0;
         done           <= 1'b0;
         busy           <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         sel_nack    <= 1'b0;
         done        <= 1'b0;
         case (state)
            IDLE: begin
               tcnt <= '0;
               if (sel_valid) sel_nack <= 1'b1;
               if (coin_ok) begin
                  credit <= sum[7:0];
                  state  <= COLLECT;
               end else if (coin_valid) begin
                  coin_reject <= 1'b1;
               end
            end
            COLLECT: begin
               // Cancel (explicit or timeout) and accepted selections consume the cycle's coin.
               if (cancel || timeout) begin
                  state          <= CHANGE;
                  busy           <= 1'b1;
                  tcnt           <= '0;
                  coin_out_valid <= 1'b1;
                  coin_out_value <= greedy(credit);
                  if (coin_valid) coin_reject <= 1'b1;
               end else if (sel_valid && sel_ok) begin
                  state      <= VEND;
                  busy       <= 1'b1;
                  tcnt       <= '0;
                  item_valid <= 1'b1;
                  item_type  <= sel_type;
                  price      <= sel_price;
                  if (coin_valid) coin_reject <= 1'b1;
               end else begin
                  if (sel_valid) sel_nack <= 1'b1;
                  if (coin_ok) credit <= sum[7:0];
                  else if (coin_valid) coin_reject <= 1'b1;
                  if (sel_valid || coin_valid) tcnt <= '0;
                  else tcnt <= tcnt + 1'b1;
               end
            end
            VEND: begin
               if (coin_valid) coin_reject <= 1'b1;
               if (item_ready) begin
                  item_valid <= 1'b0;
                  if (vend_rem == 8'd0) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     credit <= 8'd0;
                  end else begin
                     state          <= CHANGE;
                     credit         <= vend_rem;
                     coin_out_valid <= 1'b1;
                     coin_out_value <= greedy(vend_rem);
                  end
               end
            end
            CHANGE: begin
               if (coin_valid) coin_reject <= 1'b1;
               if (coin_out_ready) begin
                  if (chg_rem == 8'd0) begin
                     state          <= DONE;
                     done           <= 1'b1;
                     credit         <= 8'd0;
                     coin_out_valid <= 1'b0;
                     coin_out_value <= 8'd0;
                  end else begin
                     credit         <= chg_rem;
                     coin_out_value <= greedy(chg_rem);
                  end
               end
            end
            DONE: begin
               if (coin_valid) coin_reject <= 1'b1;
               state  <= IDLE;
               busy   <= 1'b0;
               credit <= 8'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
